// File: rtl/relu_layer_output_buffer.sv
// relu_layer_output_buffer: collects NUM_NODES fp32 neuron sums with ReLU applied,
// then streams them (plus an optional bias word) one word per cycle to the next layer.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous reset, active HIGH (name kept for the adder interface)
//   i_valid    - neuron sum valid from the upstream adder
//   i_data     - neuron sum from the upstream adder
//   o_ready    - high while collecting; input accepted on i_valid && o_ready
//   o_valid    - streamed word valid
//   o_data     - activation or bias word
//   o_last     - high with the final streamed word
//   o_overflow - sticky, set when input arrives while o_ready is low
module relu_layer_output_buffer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_NODES   = 32,
    parameter int                    APPEND_BIAS = 1,
    parameter logic [DATA_WIDTH-1:0] BIAS_WORD   = 32'h3F800000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_overflow
);

    localparam int CW = $clog2(NUM_NODES + 1);
    localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int L  = NUM_NODES + APPEND_BIAS;

    localparam logic [CW-1:0] LAST_WR = CW'(NUM_NODES - 1);
    localparam logic [CW-1:0] LAST_RD = CW'(L - 1);
    localparam logic [CW-1:0] NODES_C = CW'(NUM_NODES);

    typedef enum logic {COLLECT, STREAM} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_last_q, o_last_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_overflow_q, o_overflow_d;

    logic [DATA_WIDTH-1:0] buf_mem [NUM_NODES];
    logic                  wr_en;
    logic                  wr_last;
    logic [DATA_WIDTH-1:0] relu_data;
    logic [DATA_WIDTH-1:0] rd_word;

    // Sign bit set covers negatives, -0, -inf and negative NaNs alike.
    assign relu_data = i_data[DATA_WIDTH-1] ? '0 : i_data;
    assign o_ready   = (state_q == COLLECT);
    assign wr_en     = i_valid && o_ready;
    assign wr_last   = wr_en && (wr_cnt_q == LAST_WR);

    // Word after the activations is the bias word.
    assign rd_word = (rd_cnt_q < NODES_C) ? buf_mem[rd_cnt_q[AW-1:0]] : BIAS_WORD;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (wr_last)  state_d = STREAM;
            STREAM:  if (o_last_q) state_d = COLLECT;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        o_valid_d    = 1'b0;
        o_last_d     = 1'b0;
        o_data_d     = o_data_q;
        o_overflow_d = o_overflow_q | (i_valid & ~o_ready);
        unique case (state_q)
            COLLECT: begin
                if (wr_last) begin
                    // First word goes out the cycle after the final write,
                    // so it bypasses the buffer when slot 0 is being written now.
                    wr_cnt_d  = '0;
                    o_valid_d = 1'b1;
                    o_data_d  = (wr_cnt_q == '0) ? relu_data : buf_mem[0];
                    o_last_d  = (L == 1);
                    rd_cnt_d  = (L == 1) ? '0 : CW'(1);
                end else if (wr_en) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                end
            end
            STREAM: begin
                if (o_last_q) begin
                    rd_cnt_d = '0;
                end else begin
                    o_valid_d = 1'b1;
                    o_data_d  = rd_word;
                    o_last_d  = (rd_cnt_q == LAST_RD);
                    // Hold at the last index so the counter never exceeds L-1.
                    rd_cnt_d  = (rd_cnt_q == LAST_RD) ? rd_cnt_q : rd_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            o_data_q     <= '0;
            o_overflow_q <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            o_valid_q    <= o_valid_d;
            o_last_q     <= o_last_d;
            o_data_q     <= o_data_d;
            o_overflow_q <= o_overflow_d;
        end
    end

    // Buffer contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_cnt_q[AW-1:0]] <= relu_data;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_last     = o_last_q;
    assign o_data     = o_data_q;
    assign o_overflow = o_overflow_q;

endmodule

// File: tb/tb_relu_layer_output_buffer.sv
// tb_relu_layer_output_buffer: randomized and directed checks of the ReLU output buffer
// against a queue-free reference (relu via signed compare, stream = layer + bias).
module tb_relu_layer_output_buffer;

    localparam logic [31:0] BIAS = 32'h3F800000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready, o_valid, o_last, o_overflow;
    logic [31:0] o_data;

    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, s_ovalid, s_olast, s_ovf;
    logic [31:0] s_odata;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] lay [32];
    logic [31:0] sw [4];

    always #5 clk = ~clk;

    relu_layer_output_buffer #(
        .DATA_WIDTH(32), .NUM_NODES(32), .APPEND_BIAS(1), .BIAS_WORD(BIAS)
    ) dut (
        .clk(clk), .rst_n(rst), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
        .o_last(o_last), .o_overflow(o_overflow)
    );

    relu_layer_output_buffer #(
        .DATA_WIDTH(32), .NUM_NODES(4), .APPEND_BIAS(0), .BIAS_WORD(BIAS)
    ) dut_small (
        .clk(clk), .rst_n(rst), .i_valid(s_valid), .i_data(s_data),
        .o_ready(s_ready), .o_valid(s_ovalid), .o_data(s_odata),
        .o_last(s_olast), .o_overflow(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] w);
        return ($signed(w) < 0) ? 32'h0 : w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_layer();
        for (int i = 0; i < 32; i++) lay[i] = $urandom;
    endtask

    // Feed lay[0..31]; optional random gaps and one long pause before pause_idx.
    task automatic send_layer(input int max_gap, input int pause_idx);
        for (int i = 0; i < 32; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (i == pause_idx) gap = 40;
            for (int g = 0; g < gap; g++) begin
                i_valid = 1'b0;
                check("gap_ready", o_ready, 1);
                check("gap_valid", o_valid, 0);
                tick();
            end
            i_valid = 1'b1;
            i_data  = lay[i];
            check("acc_ready", o_ready, 1);
            check("acc_valid", o_valid, 0);
            tick();
        end
        i_valid = 1'b0;
    endtask

    // Expect the 33-word stream starting now; optionally inject input or reset.
    task automatic check_stream(input int inj_a, input int inj_b, input int abort_at);
        for (int k = 0; k < 33; k++) begin
            logic [31:0] exp;
            exp = (k < 32) ? relu_ref(lay[k]) : BIAS;
            check("str_valid", o_valid, 1);
            check("str_data", o_data, exp);
            check("str_last", o_last, (k == 32));
            check("str_ready", o_ready, 0);
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_valid", o_valid, 0);
                check("rst_ready", o_ready, 1);
                check("rst_ovf", o_overflow, 0);
                return;
            end
            i_valid = (k == inj_a) || (k == inj_b);
            i_data  = 32'hDEADBEEF;
            tick();
            i_valid = 1'b0;
        end
        check("end_valid", o_valid, 0);
        check("end_last", o_last, 0);
        check("end_ready", o_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_ready", o_ready, 1);
        check("rst_s_valid", s_ovalid, 0);
        rst = 1'b0;

        // alternating +1.0 / -1.0
        for (int i = 0; i < 32; i++) lay[i] = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
        send_layer(0, -1);
        check_stream(-1, -1, -1);
        check("alt_ovf", o_overflow, 0);

        // IEEE edge values
        lay[0] = 32'h80000000;
        lay[1] = 32'h7FC00000;
        lay[2] = 32'hFFC00000;
        lay[3] = 32'h7F800000;
        lay[4] = 32'hFF800000;
        for (int i = 5; i < 32; i++) lay[i] = 32'h40000000;
        send_layer(0, -1);
        check_stream(-1, -1, -1);

        // same alternating pattern with random gaps
        for (int i = 0; i < 32; i++) lay[i] = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
        send_layer(3, -1);
        check_stream(-1, -1, -1);

        // random data, gaps, and a long partial-fill pause
        rand_layer();
        send_layer(3, 10);
        check_stream(-1, -1, -1);

        // overflow on word 4 (cycle T+5) and on the last word
        rand_layer();
        send_layer(0, -1);
        check_stream(4, 32, -1);
        check("ovf_set", o_overflow, 1);
        rand_layer();
        send_layer(0, -1);
        check_stream(-1, -1, -1);
        check("ovf_sticky", o_overflow, 1);

        // reset at stream word 10, then a fresh pass
        rand_layer();
        send_layer(0, -1);
        check_stream(-1, -1, 10);
        rand_layer();
        send_layer(0, -1);
        check_stream(-1, -1, -1);

        // back-to-back layers
        for (int n = 0; n < 2; n++) begin
            rand_layer();
            send_layer(0, -1);
            check_stream(-1, -1, -1);
        end
        check("b2b_ovf", o_overflow, 0);

        // small instance, no bias
        for (int i = 0; i < 4; i++) sw[i] = $urandom;
        sw[1] = 32'h80000000;
        for (int i = 0; i < 4; i++) begin
            check("s_ready", s_ready, 1);
            s_valid = 1'b1;
            s_data  = sw[i];
            tick();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("s_valid", s_ovalid, 1);
            check("s_data", s_odata, relu_ref(sw[k]));
            check("s_last", s_olast, (k == 3));
            tick();
        end
        check("s_end_valid", s_ovalid, 0);
        check("s_end_ready", s_ready, 1);
        check("s_ovf", s_ovf, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/relu_layer_output_buffer.md
Name: relu_layer_output_buffer

Overview:
- Sits directly downstream of adder_33_input_pipeline_floating_point32.
- Consumes one fp32 neuron sum per o_valid pulse from the adder, applies ReLU, and collects NUM_NODES results.
- Once the layer is complete, streams the activation vector to the next layer's 33-input adder, optionally with a constant bias word appended.
- Streams exactly one word per cycle, so the next layer receives 33 contiguous valid words.

Parameters:
- DATA_WIDTH, 32, word width (IEEE-754 single).
- NUM_NODES, 32, neurons collected per layer pass.
- APPEND_BIAS, 1, if 1 append BIAS_WORD after the last activation.
- BIAS_WORD, 32'h3F800000, bias input value (+1.0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-high reset.
- i_valid  in  1  neuron sum valid (adder o_valid).
- i_data  in  DATA_WIDTH  neuron sum (adder o_data).
- o_ready  out  1  high while collecting; input is accepted only when i_valid && o_ready.
- o_valid  out  1  output word valid.
- o_data  out  DATA_WIDTH  activation or bias word.
- o_last  out  1  high with the final streamed word.
- o_overflow  out  1  sticky: an input arrived while o_ready=0.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=COLLECT, wr_cnt=0, rd_cnt=0.
  - o_valid=0, o_last=0, o_data=0, o_overflow=0, o_ready=1.
  - Buffer contents are don't-care.
- Reset has priority over all events, including a reset mid-stream. Streaming aborts immediately and no further o_valid is produced.
- ReLU on write:
  - i_data[31]=1 stores 32'h00000000. This covers negative numbers, -0, -inf and negative NaN.
  - Otherwise i_data is stored unchanged, including +NaN and +inf.
- COLLECT state:
  - o_ready=1.
  - Each accepted input writes buf[wr_cnt] and increments wr_cnt.
  - On accepting input number NUM_NODES (wr_cnt==NUM_NODES-1): wr_cnt wraps to 0 and state becomes STREAM on the next cycle.
- STREAM state:
  - o_ready=0.
  - Stream length L = NUM_NODES + APPEND_BIAS.
  - If the last input is accepted at edge T, o_valid=1 on cycles T+1 .. T+L, with no gaps.
  - o_data = buf[0] .. buf[NUM_NODES-1], then BIAS_WORD if APPEND_BIAS=1.
  - o_last=1 only on cycle T+L.
  - At the edge ending cycle T+L: state returns to COLLECT, rd_cnt=0, o_valid=0, o_last=0. o_ready=1 from cycle T+L+1.
- All outputs are registered. Latency from the last accepted input to the first output word is 1 cycle.
- o_data holds its last value when o_valid=0. It is don't-care for checking.
- Overflow:
  - i_valid=1 while o_ready=0 drops the word and sets o_overflow=1.
  - This includes the o_last cycle.
  - o_overflow clears only on reset.
- Gaps in i_valid during COLLECT are allowed. Partial fill persists indefinitely.
- Counter widths are $clog2(NUM_NODES+1); wrap is explicit, never modular overflow.

Test Plan:
- Reset, then 32 inputs: 0x3F800000 (+1.0) on even indices, 0xBF800000 (-1.0) on odd indices, one per cycle.
  - Required: 33 output words starting 1 cycle after the last input.
  - Pattern 3F800000, 00000000 repeating, word 32 = 3F800000 with o_last=1.
  - o_overflow=0.
- Edge values in: 0x80000000, 0x7FC00000, 0xFFC00000, 0x7F800000, 0xFF800000, remaining 27 words 0x40000000.
  - Required out: 00000000, 7FC00000, 00000000, 7F800000, 00000000, then 27×40000000, then 3F800000.
- Inputs with random 0–3 cycle gaps between valids.
  - Required: an identical contiguous 33-word stream.
  - o_ready stays 1 until the 32nd accept.
- Inject i_valid=1 on cycle T+5 of the stream and on the o_last cycle.
  - Required: stream data unchanged, o_overflow=1 and stays set.
  - The next layer's first word is the next input accepted after o_ready returns.
- Assert rst_n at stream word 10.
  - Required: o_valid=0 on the next cycle, o_ready=1.
  - A fresh 32-input pass streams correctly.
- Two back-to-back layers, where layer 2 inputs start the first cycle o_ready=1.
  - Required: the second stream holds layer 2 data only.
- APPEND_BIAS=0 with NUM_NODES=4.
  - Required: exactly 4 words, o_last on word 3.
